// File: rtl/div_csv_sgn_pkg.sv
// Shared types and helpers for the carry-save-input signed divider.
package div_csv_sgn_pkg;

  // Control states of the divider sequencer.
  typedef enum logic [2:0] {
    IDLE,
    RESOLVE,
    ITER,
    FIX,
    DONE
  } state_t;

  // Bits needed to count 0 .. n-1 (never less than 1).
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/div_csv_sgn_nr_step.sv
// One radix-2 non-restoring iteration on a (widthD+1)-bit partial remainder.
module div_nr_step #(
  parameter int widthD = 8
) (
  input  logic [widthD:0]   prem,
  input  logic              bit_in,
  input  logic [widthD-1:0] dmag,
  output logic [widthD:0]   prem_next,
  output logic              q_bit
);

  logic signed [widthD:0] shifted;
  logic signed [widthD:0] dext;
  logic signed [widthD:0] sum;

  // Shift in the next dividend bit, then subtract |D| when the old remainder
  // is non-negative and add it back otherwise; the new sign gives the bit.
  always_comb begin
    shifted   = $signed({prem[widthD-1:0], bit_in});
    dext      = $signed({1'b0, dmag});
    sum       = prem[widthD] ? (shifted + dext) : (shifted - dext);
    prem_next = sum;
    q_bit     = ~sum[widthD];
  end

endmodule

// File: rtl/div_csv_sgn.sv
// Sequential signed divider taking a carry-save dividend. The dividend is
// resolved once, magnitudes are divided by a non-restoring radix-2 loop, and
// signs are applied in a final fix-up cycle. Results leave over valid/ready.
module div_csv_sgn
  import div_csv_sgn_pkg::*;
#(
  parameter int widthN = 16,
  parameter int widthD = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [widthN-1:0] NS,
  input  logic [widthN-1:0] NC,
  input  logic [widthD-1:0] D,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [widthN-1:0] Q,
  output logic [widthD-1:0] R,
  output logic              DZ
);

  localparam int CW = clog2(widthN);

  state_t state, state_nx;

  logic [CW-1:0]     cnt;
  logic [widthN-1:0] ns_r;
  logic [widthN-1:0] nc_r;
  logic [widthD-1:0] d_r;
  logic              sgn_n;
  logic              sgn_d;
  logic [widthN-1:0] dq;      // |N| at start, shifts into quotient magnitude
  logic [widthD-1:0] dmag;    // |D|; widthD unsigned bits hold 2^(widthD-1)
  logic [widthD:0]   prem;    // signed partial remainder

  logic [widthN-1:0] n_sum;
  logic              d_zero;
  logic [widthD:0]   step_prem;
  logic              step_q;
  logic [widthD-1:0] rmag;

  div_nr_step #(.widthD(widthD)) u_step (
    .prem      (prem),
    .bit_in    (dq[widthN-1]),
    .dmag      (dmag),
    .prem_next (step_prem),
    .q_bit     (step_q)
  );

  // Resolved dividend, zero-divisor detect and corrected remainder magnitude.
  always_comb begin
    n_sum  = ns_r + nc_r;
    d_zero = (d_r == '0);
    rmag   = prem[widthD] ? (prem[widthD-1:0] + dmag) : prem[widthD-1:0];
  end

  assign in_ready_o  = (state == IDLE);
  assign out_valid_o = (state == DONE);

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic. A zero divisor still passes through FIX so that the
  // divide-by-zero result is registered in the same place as normal results.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid_i) state_nx = RESOLVE;
      RESOLVE: state_nx = d_zero ? FIX : ITER;
      ITER:    if (cnt == '0) state_nx = FIX;
      FIX:     state_nx = DONE;
      DONE:    if (out_ready_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, magnitude iteration and signed result fix-up.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt   <= '0;
      ns_r  <= '0;
      nc_r  <= '0;
      d_r   <= '0;
      sgn_n <= 1'b0;
      sgn_d <= 1'b0;
      dq    <= '0;
      dmag  <= '0;
      prem  <= '0;
      Q     <= '0;
      R     <= '0;
      DZ    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            ns_r <= NS;
            nc_r <= NC;
            d_r  <= D;
          end
        end
        RESOLVE: begin
          sgn_n <= n_sum[widthN-1];
          sgn_d <= d_r[widthD-1];
          dq    <= n_sum[widthN-1] ? (~n_sum + 1'b1) : n_sum;
          dmag  <= d_r[widthD-1] ? (~d_r + 1'b1) : d_r;
          prem  <= '0;
          cnt   <= CW'(widthN - 1);
        end
        ITER: begin
          prem <= step_prem;
          dq   <= {dq[widthN-2:0], step_q};
          cnt  <= cnt - 1'b1;
        end
        FIX: begin
          if (d_zero) begin
            Q  <= '1;
            R  <= n_sum[widthD-1:0];
            DZ <= 1'b1;
          end else begin
            Q  <= (sgn_n ^ sgn_d) ? (~dq + 1'b1) : dq;
            R  <= sgn_n ? (~rmag + 1'b1) : rmag;
            DZ <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_csv_sgn.sv
// Self-checking bench for div_csv_sgn (widthN=16, widthD=8).
module tb_div_csv_sgn;

  localparam int WN = 16;
  localparam int WD = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [WN-1:0] ns = '0;
  logic [WN-1:0] nc = '0;
  logic [WD-1:0] d = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [WN-1:0] q;
  logic [WD-1:0] r;
  logic          dz;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_csv_sgn #(.widthN(WN), .widthD(WD)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .NS          (ns),
    .NC          (nc),
    .D           (d),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .Q           (q),
    .R           (r),
    .DZ          (dz)
  );

  // Reference: truncating signed division on the resolved dividend.
  function automatic void model(input logic [WN-1:0] a, input logic [WN-1:0] b,
                                input logic [WD-1:0] dv, output logic [WN-1:0] eq,
                                output logic [WD-1:0] er, output logic edz);
    logic [WN-1:0] s;
    longint n, dd, qq, rr;
    s  = a + b;
    n  = longint'($signed(s));
    dd = longint'($signed(dv));
    if (dd == 0) begin
      eq  = '1;
      er  = s[WD-1:0];
      edz = 1'b1;
    end else begin
      qq  = n / dd;
      rr  = n % dd;
      eq  = qq[WN-1:0];
      er  = rr[WD-1:0];
      edz = 1'b0;
    end
  endfunction

  // Present one operand, return edges from accept to out_valid (-1 on timeout).
  task automatic start_op(input logic [WN-1:0] a, input logic [WN-1:0] b,
                          input logic [WD-1:0] dv, output int lat);
    int guard;
    ns = a; nc = b; d = dv;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, q, r, dz} !== {1'b1, 1'b0, 16'h0, 8'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b Q=%h R=%h DZ=%b required rdy=1 vld=0 Q=0 R=0 DZ=0",
               in_ready, out_valid, q, r, dz);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [WN-1:0] tns [6] = '{16'h0064, 16'hFF9D, 16'h0064, 16'hFF9D, 16'h0000, 16'h0000};
    logic [WN-1:0] tnc [6] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'h8000, 16'h0000};
    logic [WD-1:0] td  [6] = '{8'd7,     8'd7,     8'hF9,    8'hF9,    8'hFF,    8'h80};
    logic [WN-1:0] eq  [6] = '{16'd14,   16'hFFF2, 16'hFFF2, 16'd14,   16'h8000, 16'h0000};
    logic [WD-1:0] er  [6] = '{8'd1,     8'hFF,    8'd1,     8'hFF,    8'h00,    8'h00};
    int lat;
    for (int i = 0; i < 6; i++) begin
      start_op(tns[i], tnc[i], td[i], lat);
      checks++;
      if (lat != WN + 2) begin
        errors++;
        $display("FAIL latency[%0d]: got %0d required %0d", i, lat, WN + 2);
      end
      checks++;
      if ({q, r, dz} !== {eq[i], er[i], 1'b0}) begin
        errors++;
        $display("FAIL directed[%0d]: Q=%h R=%h DZ=%b required Q=%h R=%h DZ=0",
                 i, q, r, dz, eq[i], er[i]);
      end
      handshake();
    end
  endtask

  task automatic test_div_zero();
    int lat;
    start_op(16'd1000, 16'd234, 8'd0, lat);
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL dz_latency: got %0d required 2", lat);
    end
    checks++;
    if ({q, r, dz} !== {16'hFFFF, 8'hD2, 1'b1}) begin
      errors++;
      $display("FAIL div_zero: Q=%h R=%h DZ=%b required Q=ffff R=d2 DZ=1", q, r, dz);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [WN-1:0] q0;
    logic [WD-1:0] r0;
    logic dz0;
    start_op(16'h0064, 16'hFFFF, 8'd7, lat);
    q0 = q; r0 = r; dz0 = dz;
    checks++;
    if ({q0, r0, dz0} !== {16'd14, 8'd1, 1'b0}) begin
      errors++;
      $display("FAIL bp_result: Q=%h R=%h DZ=%b required Q=000e R=01 DZ=0", q0, r0, dz0);
    end
    ns = 16'h1234; nc = 16'h0; d = 8'd3; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, q, r, dz} !== {1'b1, 1'b0, q0, r0, dz0}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: vld=%b rdy=%b Q=%h R=%h DZ=%b required vld=1 rdy=0 Q=%h R=%h DZ=%b",
                 i, out_valid, in_ready, q, r, dz, q0, r0, dz0);
      end
    end
    in_valid = 1'b0;
    handshake();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release: vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_idle: vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    ns = 16'h0064; nc = 16'hFFFF; d = 8'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;               // accept
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin // resolve + 5 iterations
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, q, r, dz} !== {1'b1, 1'b0, 16'h0, 8'h0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: rdy=%b vld=%b Q=%h R=%h DZ=%b required rdy=1 vld=0 Q=0 R=0 DZ=0",
               in_ready, out_valid, q, r, dz);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    start_op(16'h0064, 16'hFFFF, 8'd7, lat);
    checks++;
    if ({lat, q, r, dz} !== {WN + 2, 16'd14, 8'd1, 1'b0}) begin
      errors++;
      $display("FAIL post_reset: lat=%0d Q=%h R=%h DZ=%b required lat=%0d Q=000e R=01 DZ=0",
               lat, q, r, dz, WN + 2);
    end
    handshake();
  endtask

  task automatic test_random();
    logic [WN-1:0] a, b, eq;
    logic [WD-1:0] dv, er;
    logic edz;
    int lat, want;
    for (int i = 0; i < 3000; i++) begin
      a  = WN'($urandom);
      b  = WN'($urandom);
      case ($urandom_range(0, 7))
        0:       dv = '0;
        1:       dv = 8'hFF;
        2:       dv = 8'h80;
        3:       dv = WD'($urandom_range(1, 4));
        default: dv = WD'($urandom);
      endcase
      model(a, b, dv, eq, er, edz);
      want = edz ? 2 : WN + 2;
      start_op(a, b, dv, lat);
      checks++;
      if ({lat, q, r, dz} !== {want, eq, er, edz}) begin
        errors++;
        $display("FAIL random[%0d] NS=%h NC=%h D=%h: lat=%0d Q=%h R=%h DZ=%b required lat=%0d Q=%h R=%h DZ=%b",
                 i, a, b, dv, lat, q, r, dz, want, eq, er, edz);
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
